// File: rtl/encoder_4to2_sync.sv
// Registered 4-to-2 priority encoder: latches request pulses and presents them highest first
// over a valid/ready handshake. Define TRISTATE_OUT_EN to float y1/y0 while disabled.
module encoder_4to2_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic in3,
    input  logic in2,
    input  logic in1,
    input  logic in0,
    input  logic ready,
    output logic y1,
    output logic y0,
    output logic valid,
    output logic ovf
);

    typedef enum logic {
        StEmpty = 1'b0,
        StHold  = 1'b1
    } state_e;

    state_e     state_q;
    logic [3:0] pend_q;
    logic [1:0] code_q;
    logic       ovf_q;

    logic [3:0] req;
    logic       acc;
    logic [3:0] clr;
    logic [3:0] pend_d;
    logic       ovf_d;
    logic [1:0] top_idx;

    always_comb begin
        req    = {in3, in2, in1, in0};
        acc    = (state_q == StHold) && ready;
        clr    = acc ? (4'b0001 << code_q) : 4'b0000;
        // A request landing on the bit being accepted re-arms it rather than overflowing.
        pend_d = (pend_q & ~clr) | req;
        ovf_d  = |(req & pend_q & ~clr);
    end

    // Highest set bit of the next pending set; 0 when nothing is pending.
    always_comb begin
        top_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pend_d[i]) begin
                top_idx = i[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            pend_q  <= 4'b0000;
            code_q  <= 2'd0;
            ovf_q   <= 1'b0;
        end else if (!en) begin
            ovf_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            case (state_q)
                StEmpty: begin
                    code_q <= top_idx;
                    if (|pend_d) begin
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    // No preemption: the presented code only changes on accept.
                    if (ready) begin
                        code_q  <= top_idx;
                        state_q <= (|pend_d) ? StHold : StEmpty;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    assign valid = en && (state_q == StHold);
    assign ovf   = en && ovf_q;

`ifdef TRISTATE_OUT_EN
    assign y1 = en ? code_q[1] : 1'bz;
    assign y0 = en ? code_q[0] : 1'bz;
`else
    assign y1 = en && code_q[1];
    assign y0 = en && code_q[0];
`endif

endmodule

// File: tb/tb_encoder_4to2_sync.sv
// Self-checking bench for encoder_4to2_sync: directed scenarios then random traffic, all
// checked against a set-based reference model of pending requests.
module tb_encoder_4to2_sync;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic in3 = 1'b0, in2 = 1'b0, in1 = 1'b0, in0 = 1'b0;
    logic ready = 1'b0;
    logic y1, y0, valid, ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: set of pending request indices and the presented index (-1 = none).
    bit pend_set [4];
    int cur = -1;
    bit m_ovf = 1'b0;

    encoder_4to2_sync dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .in3   (in3),
        .in2   (in2),
        .in1   (in1),
        .in0   (in0),
        .ready (ready),
        .y1    (y1),
        .y0    (y0),
        .valid (valid),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r_n, input bit e, input bit [3:0] req, input bit rdy);
        bit accepted;
        int best;
        if (!r_n) begin
            foreach (pend_set[i]) pend_set[i] = 1'b0;
            cur   = -1;
            m_ovf = 1'b0;
        end else if (!e) begin
            m_ovf = 1'b0;
        end else begin
            accepted = (cur >= 0) && rdy;
            if (accepted) pend_set[cur] = 1'b0;
            m_ovf = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if (pend_set[i]) m_ovf = 1'b1;
                    pend_set[i] = 1'b1;
                end
            end
            if (cur < 0 || accepted) begin
                best = -1;
                for (int i = 0; i < 4; i++) if (pend_set[i]) best = i;
                cur = best;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [1:0] exp_y;
        logic [1:0] idx;
        idx = (cur >= 0) ? cur[1:0] : 2'd0;
`ifdef TRISTATE_OUT_EN
        exp_y = en ? idx : 2'bzz;
`else
        exp_y = en ? idx : 2'b00;
`endif
        check_val({tag, ".valid"}, {3'b000, valid}, {3'b000, en && (cur >= 0)});
        check_val({tag, ".y"}, {2'b00, y1, y0}, {2'b00, exp_y});
        check_val({tag, ".ovf"}, {3'b000, ovf}, {3'b000, en && m_ovf});
    endtask

    task automatic cycle(input string tag, input bit r_n, input bit e, input bit [3:0] req,
                         input bit rdy);
        rst_n = r_n;
        en    = e;
        {in3, in2, in1, in0} = req;
        ready = rdy;
        @(posedge clk);
        model_step(r_n, e, req, rdy);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        foreach (pend_set[i]) pend_set[i] = 1'b0;

        // Reset dominates traffic.
        cycle("rst", 0, 1, 4'b1111, 1);
        cycle("rst", 0, 1, 4'b1111, 1);
        check_val("rst_const", {valid, y1, y0, ovf}, 4'b0000);
        cycle("post_rst", 1, 1, 4'b0000, 1);
        check_val("post_rst_valid", {3'b000, valid}, 4'b0000);

        // Single event.
        cycle("single", 1, 1, 4'b0010, 1);
        check_val("single_code", {1'b0, valid, y1, y0}, 4'b0101);
        cycle("single_drain", 1, 1, 4'b0000, 1);
        check_val("single_done", {3'b000, valid}, 4'b0000);

        // Priority with backpressure, then drain in order 3, 2, 0.
        cycle("prio", 1, 1, 4'b1101, 0);
        cycle("prio_stall", 1, 1, 4'b0000, 0);
        cycle("prio_stall", 1, 1, 4'b0000, 0);
        check_val("prio_hold", {1'b0, valid, y1, y0}, 4'b0111);
        cycle("prio_drain", 1, 1, 4'b0000, 1);
        check_val("prio_second", {1'b0, valid, y1, y0}, 4'b0110);
        cycle("prio_drain", 1, 1, 4'b0000, 1);
        check_val("prio_third", {1'b0, valid, y1, y0}, 4'b0100);
        cycle("prio_drain", 1, 1, 4'b0000, 1);
        check_val("prio_empty", {3'b000, valid}, 4'b0000);

        // Overflow on a held code, then re-arm on the accepting edge.
        cycle("ovf_load", 1, 1, 4'b0100, 0);
        cycle("ovf_drop", 1, 1, 4'b0100, 0);
        check_val("ovf_pulse", {3'b000, ovf}, 4'b0001);
        cycle("ovf_rearm", 1, 1, 4'b0100, 1);
        check_val("ovf_rearm", {1'b0, ovf, y1, y0}, 4'b0010);
        cycle("ovf_drain", 1, 1, 4'b0000, 1);

        // Enable gating ignores in3 and re-presents the held code.
        cycle("en_load", 1, 1, 4'b0010, 0);
        cycle("en_off", 1, 0, 4'b1000, 1);
        cycle("en_off", 1, 0, 4'b1000, 1);
        cycle("en_off", 1, 0, 4'b1000, 1);
        check_val("en_off_valid", {3'b000, valid}, 4'b0000);
        cycle("en_on", 1, 1, 4'b0000, 0);
        check_val("en_on_code", {1'b0, valid, y1, y0}, 4'b0101);
        cycle("en_drain", 1, 1, 4'b0000, 1);
        check_val("en_no_in3", {3'b000, valid}, 4'b0000);

        // Reset mid-operation discards pending events.
        cycle("mid_load", 1, 1, 4'b1001, 0);
        cycle("mid_rst", 0, 1, 4'b0000, 0);
        check_val("mid_rst", {1'b0, valid, y1, y0}, 4'b0000);
        for (int i = 0; i < 3; i++) cycle("mid_after", 1, 1, 4'b0000, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit [3:0] r;
            r = 4'($urandom) & 4'($urandom) & 4'($urandom);
            cycle("rand", ($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0), r,
                  1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
